mem_reg_loader: RTL and testbench
=================================

Name: mem_reg_loader

Overview:
- Memory-to-register-bank transfer sequencer: the read-back direction of the existing register-bank -> ALU -> memory write path.
- On a start pulse it reads COUNT consecutive memory words from a base address and writes them into consecutive register-bank entries.
- Drives the register bank's write port (data, address, write-enable) and the memory's read port. Sits beside the datapath as its load/writeback engine.

Parameters:
- DATA_W, 32, word width of memory and register bank
- ADDR_W, 5, memory and register address width (32 entries each)
- CNT_W, 6, transfer-length width (0..32 words)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mem_base  in  ADDR_W  first memory address; sampled with start
- reg_base  in  ADDR_W  first register address; sampled with start
- count  in  CNT_W  number of words; sampled with start; values >32 are clamped to 32
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse when the transfer completes
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data; valid exactly one cycle after mem_rd
- reg_di  out  DATA_W  register-bank write data
- reg_dir  out  ADDR_W  register-bank write address
- reg_write  out  1  register-bank write enable

Behaviour:
- Reset (asynchronous, any state): state IDLE. busy, done, mem_rd and reg_write = 0. mem_addr, reg_dir and reg_di = 0. Internal counters are cleared.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - start=1 latches mem_base, reg_base and the clamped count.
  - If count==0, go to DONE (no memory or register access). Otherwise go to READ.
- READ: mem_rd=1, mem_addr=current memory pointer. Next state is WAIT.
- WAIT: mem_rd=0. mem_rdata is captured into the data register at the end of the cycle. Next state is WRITE.
- WRITE:
  - reg_write=1, reg_di=captured word, reg_dir=current register pointer.
  - Both pointers increment modulo 2^ADDR_W (31 wraps to 0). Remaining count decrements.
  - If remaining count is now 0, go to DONE; else go to READ.
- DONE: done=1 for exactly one cycle, busy=1. Next state is IDLE.
- Timing: 3 cycles per word.
  - Start accepted at edge T gives READ in cycle T+1 and the first reg_write in cycle T+3.
  - The done pulse occurs in cycle T+3N+1.
  - count==0 gives done in cycle T+1.
- Outputs are registered/decoded from state only, with no combinational path from start.
- start asserted while busy is ignored; there is no queueing.
- reg_di and reg_dir hold their last values outside WRITE. reg_write is high only in WRITE.
- mem_rd and reg_write are never high in the same cycle.
- Overlapping regions are allowed; each word is read before it is written, one word at a time.

Optional Feature:
- Macro: MEM_REG_LOADER_R0_PROTECT_EN.
- Defined: in WRITE, when reg_dir==0, reg_write is forced to 0. Pointers and count still advance, so the transfer length and done timing are unchanged.
- Undefined: register 0 is written like any other entry.

Decomposition:
- Shared package mem_reg_loader_pkg holds:
  - the state enum (IDLE, READ, WAIT, WRITE, DONE);
  - the constants DATA_W, ADDR_W, CNT_W;
  - MAX_WORDS = 2^ADDR_W, used for clamping.
- One natural sub-module, mem_reg_loader_ptr: a wrapping address pointer with load/increment. It is instantiated twice, once for the memory pointer and once for the register pointer.
- FSM and data capture stay in the top module.

Test Plan:
- Basic transfer: memory[4..6]=0xA,0xB,0xC; start with mem_base=4, reg_base=10, count=3. Required: writes R10=0xA, R11=0xB, R12=0xC; reg_write high in cycles T+3, T+6, T+9; done at T+10.
- Wrap-around: mem_base=30, reg_base=31, count=3. Required: mem_addr sequence 30, 31, 0; reg_dir sequence 31, 0, 1; done after 3 words.
- Zero and clamp: count=0 gives done at T+1 with no mem_rd/reg_write. count=40 gives exactly 32 writes, then done.
- Start while busy: a second start pulse during WAIT of word 1 (mem_base=0) is ignored; the original sequence and done timing are unchanged.
- Reset mid-transfer: rst asserted in WRITE of word 2. Required: reg_write, busy and done drop to 0 asynchronously; IDLE after release; no further writes; a new start works normally.
- R0 protect (macro defined): reg_base=0, count=2. Required: no reg_write for reg_dir=0; R1 written; done at T+7. With the macro undefined, R0 is written.

Source files
------------

// File: rtl/mem_reg_loader_pkg.sv
// mem_reg_loader_pkg: shared widths, word limit and FSM states for the memory-to-register loader
package mem_reg_loader_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W = 6;
  localparam int MAX_WORDS = 1 << ADDR_W;
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_reg_loader_ptr.sv
// mem_reg_loader_ptr: wrapping address pointer with load and increment
module mem_reg_loader_ptr import mem_reg_loader_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] ptr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (load) ptr <= load_val;
    else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/mem_reg_loader.sv
// mem_reg_loader: copies count memory words into consecutive registers, 3 cycles per word; MEM_REG_LOADER_R0_PROTECT_EN blocks writes to register 0
module mem_reg_loader import mem_reg_loader_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] mem_base,
  input  logic [ADDR_W-1:0] reg_base,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] reg_di,
  output logic [ADDR_W-1:0] reg_dir,
  output logic              reg_write
);
  state_t state, next;
  logic [CNT_W-1:0] cnt, n_clamp;
  logic [ADDR_W-1:0] reg_ptr;
  logic accept;
  assign accept = state == IDLE && start;
  assign n_clamp = count > CNT_W'(MAX_WORDS) ? CNT_W'(MAX_WORDS) : count;
  mem_reg_loader_ptr u_mem_ptr (
    .clk(clk), .rst(rst), .load(accept), .inc(state == WRITE), .load_val(mem_base), .ptr(mem_addr)
  );
  mem_reg_loader_ptr u_reg_ptr (
    .clk(clk), .rst(rst), .load(accept), .inc(state == WRITE), .load_val(reg_base), .ptr(reg_ptr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE  ? (start ? (n_clamp == '0 ? DONE : READ) : IDLE) :
           state == READ  ? WAIT :
           state == WAIT  ? WRITE :
           state == WRITE ? (cnt == CNT_W'(1) ? DONE : READ) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      reg_di <= '0;
      reg_dir <= '0;
    end else begin
      if (accept) cnt <= n_clamp;
      else if (state == WRITE) cnt <= cnt - 1'b1;
      if (state == WAIT) begin
        reg_di <= mem_rdata;
        reg_dir <= reg_ptr;
      end
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign mem_rd = state == READ;
`ifdef MEM_REG_LOADER_R0_PROTECT_EN
  assign reg_write = state == WRITE && reg_dir != '0;
`else
  assign reg_write = state == WRITE;
`endif
endmodule

// File: tb/tb_mem_reg_loader.sv
// tb_mem_reg_loader: scoreboard bench checking read addresses, writes and done timing
module tb_mem_reg_loader;
  logic clk = 0, rst = 1, start = 0;
  logic [4:0] mem_base = 0, reg_base = 0, mem_addr, reg_dir;
  logic [5:0] count = 0;
  logic busy, done, mem_rd, reg_write;
  logic [31:0] mem_rdata = 0, reg_di;
  logic [31:0] mem [32];
  int cyc = 0, n_tests = 0, n_fail = 0, t0 = 0;
  typedef struct {logic [4:0] a; logic [31:0] d; int c;} ev_t;
  ev_t rq[$], wq[$];
  int dq[$];
  mem_reg_loader dut (
    .clk(clk), .rst(rst), .start(start), .mem_base(mem_base), .reg_base(reg_base),
    .count(count), .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .reg_di(reg_di), .reg_dir(reg_dir), .reg_write(reg_write)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    ev_t e;
    if (mem_rd || reg_write) check("rd_wr_excl", {31'b0, mem_rd & reg_write}, 0);
    if (mem_rd) begin
      if (rq.size() == 0) check("rd_unexp", {31'b0, mem_rd}, 0);
      else begin
        e = rq.pop_front();
        check("rd_addr", {27'b0, mem_addr}, {27'b0, e.a});
        check("rd_cyc", cyc, e.c);
      end
    end
    if (reg_write) begin
      if (wq.size() == 0) check("wr_unexp", {31'b0, reg_write}, 0);
      else begin
        e = wq.pop_front();
        check("wr_dir", {27'b0, reg_dir}, {27'b0, e.a});
        check("wr_di", reg_di, e.d);
        check("wr_cyc", cyc, e.c);
      end
    end
    if (done) begin
      if (dq.size() == 0) check("done_unexp", {31'b0, done}, 0);
      else check("done_cyc", cyc, dq.pop_front());
    end
  end
  task automatic push_exp(input logic [4:0] mb, input logic [4:0] rb, input int n);
    for (int k = 0; k < n; k++) begin
      logic [4:0] ma, ra;
      ma = mb + 5'(k);
      ra = rb + 5'(k);
      rq.push_back('{ma, 32'h0, t0 + 3 * k});
`ifdef MEM_REG_LOADER_R0_PROTECT_EN
      if (ra != 0)
`endif
      wq.push_back('{ra, mem[ma], t0 + 3 * k + 2});
    end
    dq.push_back(t0 + 3 * n);
  endtask
  task automatic do_start(input logic [4:0] mb, input logic [4:0] rb, input logic [5:0] n);
    @(negedge clk);
    mem_base = mb;
    reg_base = rb;
    count = n;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    t0 = cyc;
    push_exp(mb, rb, n > 32 ? 32 : int'(n));
  endtask
  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    check(tag, {31'b0, busy}, 0);
    repeat (2) @(negedge clk);
    check({tag, "_rq"}, rq.size(), 0);
    check({tag, "_wq"}, wq.size(), 0);
    check({tag, "_dq"}, dq.size(), 0);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[4] = 32'hA;
    mem[5] = 32'hB;
    mem[6] = 32'hC;
    #12;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_rd", {31'b0, mem_rd}, 0);
    check("rst_wr", {31'b0, reg_write}, 0);
    check("rst_addr", {27'b0, mem_addr}, 0);
    check("rst_dir", {27'b0, reg_dir}, 0);
    check("rst_di", reg_di, 0);
    @(negedge clk) rst = 0;
    do_start(4, 10, 3);
    wait_idle("basic");
    check("hold_dir", {27'b0, reg_dir}, 12);
    check("hold_di", reg_di, 32'hC);
    do_start(30, 31, 3);
    wait_idle("wrap");
    do_start(7, 3, 0);
    wait_idle("zero");
    do_start(0, 0, 40);
    wait_idle("clamp");
    do_start(4, 10, 3);
    @(negedge clk);
    start = 1;
    mem_base = 0;
    reg_base = 20;
    count = 5;
    @(negedge clk);
    start = 0;
    wait_idle("busy_start");
    do_start(8, 16, 4);
    while (cyc < t0 + 5) @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_wr", {31'b0, reg_write}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_done", {31'b0, done}, 0);
    rq.delete();
    wq.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 0);
    do_start(2, 5, 2);
    wait_idle("after_rst");
    do_start(9, 0, 2);
    wait_idle("r0");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
